// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the fetch stage: opcode values, the canonical NOP,
// instruction field bit positions and the fetch FSM state encoding.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus: the fetch unit is the master, memory the slave.
interface instr_fetch_unit_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Fetch buffer of {pc, instruction} pairs; the head entry is read combinationally so a
// pushed word is visible to decode on the cycle after the push.
module fetch_fifo #(
  parameter int  XLEN  = 32,
  parameter int  DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] push_pc,
  input  logic [31:0]     push_instr,
  output logic [XLEN-1:0] head_pc,
  output logic [31:0]     head_instr,
  output logic [CW-1:0]   count
);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; the count alone defines which entries are meaningful,
  // so the array maps onto plain RAM/register cells without a reset network.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr_q]    <= push_pc;
      instr_mem[wr_ptr_q] <= push_instr;
    end
  end

  assign head_pc    = pc_mem[rd_ptr_q];
  assign head_instr = instr_mem[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding memory fetch FSM with epoch tagging so
// redirects discard stale responses, a small fetch buffer and decode field slicing.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  imem,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  input  logic                id_ready,
  output logic                if_valid,
  output logic [XLEN-1:0]     if_pc,
  output logic [31:0]         instr,
  output logic [6:0]          opcode,
  output logic [2:0]          funct3,
  output logic [6:0]          funct7,
  output logic [4:0]          in_shamt,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [4:0]          rd
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            epoch_q, epoch_d;
  logic            tag_q, tag_d;
  logic            outstanding_q, outstanding_d;

  logic            fetch_req;
  logic            fifo_push;
  logic            fifo_pop;
  logic            credit_ok;
  logic [CW-1:0]   fifo_count;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_instr;

  // A request is only issued when a slot is guaranteed for its response.
  assign credit_ok = (int'(fifo_count) + int'(outstanding_q)) < FIFO_DEPTH;

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    epoch_d       = epoch_q;
    tag_d         = tag_q;
    outstanding_d = outstanding_q;
    fetch_req     = 1'b0;
    fifo_push     = 1'b0;

    unique case (state_q)
      FETCH_IDLE: state_d = FETCH_REQ;
      FETCH_REQ: begin
        fetch_req = credit_ok && !redirect;
        if (fetch_req && imem.imem_gnt) begin
          pc_d          = pc_q + XLEN'(4);
          outstanding_d = 1'b1;
          tag_d         = epoch_q;
          state_d       = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem.imem_rvalid) begin
          outstanding_d = 1'b0;
          fifo_push     = (tag_q == epoch_q) && !redirect;
          state_d       = FETCH_REQ;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase

    // A response still in flight keeps the FSM in WAIT; the epoch flip marks it stale.
    if (redirect) begin
      pc_d    = redirect_pc & ~XLEN'(3);
      epoch_d = ~epoch_q;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FETCH_IDLE;
      pc_q          <= RESET_PC;
      epoch_q       <= 1'b0;
      tag_q         <= 1'b0;
      outstanding_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epoch_q       <= epoch_d;
      tag_q         <= tag_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign fifo_pop = if_valid && id_ready && !redirect;

  fetch_fifo #(
    .XLEN  (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .flush      (redirect),
    .push_pc    (pc_q - XLEN'(4)),
    .push_instr (imem.imem_rdata),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (fifo_count)
  );

  assign imem.imem_req  = fetch_req;
  assign imem.imem_addr = pc_q;

  assign if_valid = (fifo_count != '0);
  assign if_pc    = if_valid ? head_pc : '0;
  assign instr    = if_valid ? head_instr : INSTR_NOP;

  assign opcode   = instr[OPCODE_MSB:OPCODE_LSB];
  assign rd       = instr[RD_MSB:RD_LSB];
  assign funct3   = instr[FUNCT3_MSB:FUNCT3_LSB];
  assign rs1      = instr[RS1_MSB:RS1_LSB];
  assign rs2      = instr[RS2_MSB:RS2_LSB];
  assign in_shamt = instr[RS2_MSB:RS2_LSB];
  assign funct7   = instr[FUNCT7_MSB:FUNCT7_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed boot/backpressure/stall/redirect/wrap/reset
// scenarios followed by randomized traffic, checked against program-order expectations.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  in_shamt, rs1, rs2, rd;

  instr_fetch_unit_if #(.XLEN(XLEN)) bus ();

  instr_fetch_unit #(
    .XLEN       (XLEN),
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .instr       (instr),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .in_shamt    (in_shamt),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] exp_tail;
  logic [31:0] grants[$];
  bit          pend = 1'b0;
  logic [31:0] pend_addr;
  int          pend_wait = 0;
  int          rsp_lo = 0;
  int          rsp_hi = 0;
  int          pops = 0;
  int          pops_before;
  bit          mon_en = 1'b0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_addr;

  // Instruction memory contents: R-type opcode, address-dependent upper bits; word 0 = 0x33.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [24:0] hi;
    hi = 25'(((a >> 2) ^ (a >> 27)) * 32'h0000_9E37);
    return {hi, OP_R};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: exp_tail, word: mem_word(exp_tail)});
      exp_tail = exp_tail + 32'd4;
    end
  endtask

  // Decode must see sequential program order starting at the (aligned) target.
  task automatic model_restart(input logic [31:0] pc);
    exp_q.delete();
    exp_tail = pc & ~32'h3;
    top_up();
  endtask

  // One cycle of stimulus plus the memory responder.
  task automatic step(input bit g, input bit rdy, input bit redir, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    if (pend && pend_wait == 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend_addr);
      pend            = 1'b0;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
      if (pend) pend_wait--;
    end
    bus.imem_gnt = g;
    id_ready     = rdy;
    redirect     = redir;
    redirect_pc  = rpc;
    if (redir) model_restart(rpc);
    else top_up();
    #1;
    if (bus.imem_req && bus.imem_gnt) begin
      check("single_outstanding", 64'(pend), 64'(0));
      pend      = 1'b1;
      pend_addr = bus.imem_addr;
      pend_wait = int'($urandom_range(rsp_hi, rsp_lo));
      grants.push_back(bus.imem_addr);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst             = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    redirect        = 1'b0;
    id_ready        = 1'b0;
    pend            = 1'b0;
    rsp_lo          = 0;
    rsp_hi          = 0;
    grants.delete();
    model_restart(RESET_PC);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: consumes head words and compares against the expected program stream.
  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
    end else if (mon_en) begin
      if (prev_hold && !redirect)
        check("req_stable", 64'({bus.imem_req, bus.imem_addr}), 64'({1'b1, prev_addr}));
      prev_hold = bus.imem_req && !bus.imem_gnt;
      prev_addr = bus.imem_addr;

      if (if_valid) begin
        if (id_ready && !redirect) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow: got pc %0h with no expected entry", if_pc);
          end else begin
            mon_e = exp_q.pop_front();
            check("sb_pc", 64'(if_pc), 64'(mon_e.pc));
            check("sb_instr", 64'(instr), 64'(mon_e.word));
            check("sb_fields", 64'({funct7, rs2, rs1, funct3, rd, opcode}), 64'(mon_e.word));
            check("sb_shamt", 64'(in_shamt), 64'(mon_e.word[24:20]));
            pops++;
          end
        end
      end else begin
        check("idle_nop", 64'({if_pc, instr}), {32'h0, INSTR_NOP});
      end
    end
  end

  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    id_ready        = 1'b0;
    rst             = 1'b0;
    model_restart(RESET_PC);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 64'(bus.imem_req), 64'(0));
    check("rst_addr", 64'(bus.imem_addr), 64'(RESET_PC));
    check("rst_valid", 64'(if_valid), 64'(0));
    check("rst_if_pc", 64'(if_pc), 64'(0));
    check("rst_instr", 64'(instr), 64'(INSTR_NOP));
    check("rst_fields", 64'({funct7, rs2, rs1, funct3, rd, opcode}), 64'(INSTR_NOP));
    rst    = 1'b1;
    mon_en = 1'b1;

    // Boot
    repeat (3) step(1'b1, 1'b1, 1'b0, '0);
    check("boot_valid", 64'(if_valid), 64'(1));
    check("boot_pc", 64'(if_pc), 64'(0));
    check("boot_opcode", 64'(opcode), 64'(OP_R));
    repeat (4) step(1'b1, 1'b1, 1'b0, '0);
    check("boot_ngrants", 64'(grants.size() >= 3), 64'(1));
    check("boot_addr0", 64'(grants.size() > 0 ? grants[0] : 32'hdead_beef), 64'(32'h0));
    check("boot_addr1", 64'(grants.size() > 1 ? grants[1] : 32'hdead_beef), 64'(32'h4));
    check("boot_addr2", 64'(grants.size() > 2 ? grants[2] : 32'hdead_beef), 64'(32'h8));

    // Backpressure
    do_reset();
    repeat (10) step(1'b1, 1'b0, 1'b0, '0);
    check("bp_grants", 64'(grants.size()), 64'(2));
    check("bp_req_low", 64'(bus.imem_req), 64'(0));
    check("bp_head_pc", 64'(if_pc), 64'(0));
    repeat (6) step(1'b1, 1'b1, 1'b0, '0);
    check("bp_resume", 64'(grants.size() > 2 ? grants[2] : 32'hdead_beef), 64'(32'h8));

    // Memory stall
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      check("stall_req_addr", 64'({bus.imem_req, bus.imem_addr}), 64'({1'b1, RESET_PC}));
    end
    repeat (4) step(1'b1, 1'b1, 1'b0, '0);
    check("stall_grant", 64'(grants.size() > 0 ? grants[0] : 32'hdead_beef), 64'(RESET_PC));

    // Redirect while a fetch is in flight
    do_reset();
    rsp_lo = 2;
    rsp_hi = 2;
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0103);
    step(1'b0, 1'b1, 1'b0, '0);
    check("rd_addr", 64'(bus.imem_addr), 64'(32'h100));
    step(1'b0, 1'b1, 1'b0, '0);
    rsp_lo = 0;
    rsp_hi = 0;
    step(1'b1, 1'b1, 1'b0, '0);
    check("rd_stale_dropped", 64'(if_valid), 64'(0));
    check("rd_reissue", 64'(grants.size() > 1 ? grants[1] : 32'hdead_beef), 64'(32'h100));
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    check("rd_first_pc", 64'({if_valid, if_pc}), 64'({1'b1, 32'h100}));

    // Redirect + pop + rvalid in the same cycle
    do_reset();
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    check("sim_pre_valid", 64'(if_valid), 64'(1));
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    step(1'b1, 1'b1, 1'b0, '0);
    check("sim_flushed", 64'(if_valid), 64'(0));
    check("sim_nop", 64'(instr), 64'(INSTR_NOP));
    check("sim_req", 64'({bus.imem_req, bus.imem_addr}), 64'({1'b1, 32'h200}));
    repeat (3) step(1'b1, 1'b1, 1'b0, '0);

    // PC wrap, then asynchronous reset in the middle of WAIT
    do_reset();
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    step(1'b1, 1'b0, 1'b0, '0);
    check("wrap_addr_top", 64'(bus.imem_addr), 64'(32'hFFFF_FFFC));
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    check("wrap_addr_zero", 64'({bus.imem_req, bus.imem_addr}), 64'({1'b1, 32'h0}));
    check("wrap_head_pc", 64'(if_pc), 64'(32'hFFFF_FFFC));
    rsp_lo = 3;
    rsp_hi = 3;
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    #4;
    rst = 1'b0;
    #1;
    check("async_req", 64'(bus.imem_req), 64'(0));
    check("async_addr", 64'(bus.imem_addr), 64'(RESET_PC));
    check("async_valid", 64'(if_valid), 64'(0));
    check("async_instr", 64'(instr), 64'(INSTR_NOP));
    #1;
    rst = 1'b1;
    model_restart(RESET_PC);
    pend_wait = 0;
    rsp_lo = 0;
    rsp_hi = 0;
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    check("late_rvalid_ignored", 64'(if_valid), 64'(0));
    pops_before = pops;
    repeat (4) step(1'b1, 1'b1, 1'b0, '0);
    check("post_reset_fetch", 64'(pops > pops_before), 64'(1));

    // Randomized traffic
    do_reset();
    rsp_lo = 0;
    rsp_hi = 2;
    pops_before = pops;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99, 0) < 70, $urandom_range(99, 0) < 60,
           $urandom_range(99, 0) < 5, $urandom);
    end
    check("random_progress", 64'(pops - pops_before > 200), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
